branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Consumer end of the direction predictor. Captures each 2-bit prediction issued at IF and holds it in an in-order queue until the branch resolves in EX.
- At EX, compares the held prediction with the actual outcome. On a mismatch it issues a flush and redirect.
- Drives the predictor-update bus (pc, outcome, old counter) and keeps branch and misprediction performance counters.
- Sits between the IF stage, the EX comparator and the predictor's write port.

Parameters:
DEPTH, 4, number of in-flight branch entries (power of 2, at least 2)
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; asynchronous assert, active-low
if_valid  in  1  IF hands an instruction to ID this cycle (not stalled)
if_is_br  in  1  that instruction's opcode is op_br
if_pc  in  32  PC of that instruction
if_pred  in  2  predictor counter for if_pc; predicted taken = if_pred[1]
ex_valid  in  1  a conditional branch resolves in EX this cycle
ex_pc  in  32  PC of the resolving branch
ex_taken  in  1  comparator result for that branch
ex_target  in  32  computed branch target
full  out  1  queue holds DEPTH entries; IF must stall branch issue
flush  out  1  one-cycle pulse: squash IF/ID/EX
redirect_pc  out  32  fetch PC, valid while flush=1
upd_valid  out  1  one-cycle predictor write strobe
upd_pc  out  32  index PC for the update
upd_taken  out  1  actual outcome
upd_pred  out  2  counter value originally predicted (predictor computes new state)
br_count  out  CNT_W  branches resolved
mispred_count  out  CNT_W  mispredictions
err_order  out  1  sticky: queue-head PC mismatch or pop of an empty queue

Behaviour:
- Reset (rst_n=0, asynchronous) clears:
  - all queue entries, both pointers and the occupancy count;
  - flush, upd_valid, full and err_order to 0;
  - redirect_pc, upd_pc, upd_pred, upd_taken, br_count and mispred_count to 0.
  - Reset asserted mid-operation drops all in-flight entries immediately.
- Queue entry = {pc[31:0], pred[1:0]}. Pointers wrap modulo DEPTH. Occupancy counter is clog2(DEPTH)+1 bits wide.
- Push condition: if_valid & if_is_br & ~full & ~flush.
  - full is evaluated before any same-cycle pop, so there is no push on a full queue even if ex_valid pops that cycle.
- Pop condition: ex_valid. The head entry is compared combinationally in the same cycle.
  - Empty queue at pop: use pred=2'b01 (not-taken), set err_order, and do not move the read pointer. A same-cycle push still succeeds.
  - Head pc != ex_pc: set err_order. Resolution still uses the head entry's pred and ex_pc.
- Resolution (pop cycle N), all outputs registered so they are visible in cycle N+1:
  - upd_valid=1, upd_pc=ex_pc, upd_taken=ex_taken, upd_pred=head pred.
  - br_count += 1, saturating at all-ones.
  - mispredict = head pred[1] XOR ex_taken.
    - If mispredict: flush=1; redirect_pc = ex_taken ? ex_target : ex_pc+4 (32-bit wrap); mispred_count += 1, saturating.
    - Otherwise flush=0.
- flush and upd_valid are high for exactly one cycle per resolution. Back-to-back resolutions give back-to-back pulses.
- Cycle with flush=1:
  - The queue is cleared (pointers and count to 0) after the same-cycle pop is applied.
  - Pushes are suppressed; any push in cycle N was wrong-path and is discarded by the clear.
  - An ex_valid arriving while flush=1 is ignored: pipeline contract says EX is squashed.
- redirect_pc and the upd_* data fields hold their last value when not strobed.
- err_order is cleared only by reset.

Test Plan:
1. Reset: drive rst_n=0 mid-stream with 3 entries queued -> all outputs 0 immediately; after release, full=0 and a pop sets err_order=1.
2. Correct prediction: push pc=0x100, pred=2'b10; two cycles later ex_valid, ex_pc=0x100, ex_taken=1 -> next cycle upd_valid=1, upd_pred=2'b10, upd_taken=1, flush=0, br_count=1, mispred_count=0.
3. Mispredict, not-taken to taken: push 0x200, pred=2'b01; resolve ex_taken=1, ex_target=0x240 -> flush=1, redirect_pc=0x240, mispred_count=1.
4. Mispredict, taken to not-taken, with younger entries queued: push 0x300 (pred 11), then 0x304 and 0x308; resolve 0x300 not-taken -> redirect_pc=0x304; queue empty after the flush cycle; a push during the flush cycle is dropped.
5. Full/wrap: push 4 branches -> full=1 and a 5th push is blocked, even with a same-cycle pop. Resolve all 4 in order, then push 4 more -> pointers wrap, PCs match, err_order stays 0.
6. Ordering error: queue head 0x400, resolve with ex_pc=0x404 -> err_order=1 (sticky), upd_pc=0x404, upd_pred taken from the head entry.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Bus bundle between the IF/EX pipeline side and the branch resolve unit.
// master = pipeline/predictor side, slave = the resolve unit itself.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 32
);
  // IF-stage capture of predictions
  logic             if_valid;
  logic             if_is_br;
  logic [31:0]      if_pc;
  logic [1:0]       if_pred;
  // EX-stage resolution
  logic             ex_valid;
  logic [31:0]      ex_pc;
  logic             ex_taken;
  logic [31:0]      ex_target;
  // Results back to the pipeline and predictor
  logic             full;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [1:0]       upd_pred;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;
  logic             err_order;

  modport master (
    output if_valid, if_is_br, if_pc, if_pred,
    output ex_valid, ex_pc, ex_taken, ex_target,
    input  full, flush, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_pred,
    input  br_count, mispred_count, err_order
  );

  modport slave (
    input  if_valid, if_is_br, if_pc, if_pred,
    input  ex_valid, ex_pc, ex_taken, ex_target,
    output full, flush, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_pred,
    output br_count, mispred_count, err_order
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: holds IF-time predictions in an in-order queue,
// checks them against the EX outcome, raises flush/redirect on a
// mispredict, drives the predictor update bus and counts branches.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  // Queue storage and bookkeeping
  logic [31:0]      pc_q   [DEPTH];
  logic [1:0]       pred_q [DEPTH];
  logic [PTR_W-1:0] rptr_q, wptr_q;
  logic [OCC_W-1:0] occ_q,  occ_d;

  // Registered outputs
  logic             flush_q;
  logic [31:0]      redirect_pc_q;
  logic             upd_valid_q;
  logic [31:0]      upd_pc_q;
  logic             upd_taken_q;
  logic [1:0]       upd_pred_q;
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] mispred_count_q;
  logic             err_order_q;

  logic             full_w, empty_w;
  logic             push_en, pop_en, pop_mv;
  logic [31:0]      head_pc;
  logic [1:0]       head_pred;
  logic             mispredict;
  logic             order_bad;

  assign full_w  = (occ_q == OCC_W'(DEPTH));
  assign empty_w = (occ_q == '0);

  // Push/pop decisions and head-entry comparison for this cycle
  always_comb begin
    // While flushing, IF is on the wrong path and EX is squashed.
    push_en    = bus.if_valid & bus.if_is_br & ~full_w & ~flush_q;
    pop_en     = bus.ex_valid & ~flush_q;
    // An empty-queue pop resolves with a weak not-taken default and
    // leaves the read pointer alone.
    pop_mv     = pop_en & ~empty_w;
    head_pc    = pc_q[rptr_q];
    head_pred  = empty_w ? 2'b01 : pred_q[rptr_q];
    mispredict = head_pred[1] ^ bus.ex_taken;
    order_bad  = pop_en & (empty_w | (head_pc != bus.ex_pc));
    occ_d      = occ_q + OCC_W'(push_en) - OCC_W'(pop_mv);
  end

  // Queue storage, pointers and occupancy; a flush cycle empties the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        pred_q[i] <= '0;
      end
      rptr_q <= '0;
      wptr_q <= '0;
      occ_q  <= '0;
    end else if (flush_q) begin
      rptr_q <= '0;
      wptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push_en) begin
        pc_q[wptr_q]   <= bus.if_pc;
        pred_q[wptr_q] <= bus.if_pred;
        wptr_q         <= wptr_q + PTR_W'(1);
      end
      if (pop_mv) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      occ_q <= occ_d;
    end
  end

  // Resolution outputs: strobes pulse one cycle, data fields hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q         <= 1'b0;
      redirect_pc_q   <= '0;
      upd_valid_q     <= 1'b0;
      upd_pc_q        <= '0;
      upd_taken_q     <= 1'b0;
      upd_pred_q      <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
      err_order_q     <= 1'b0;
    end else begin
      flush_q     <= pop_en & mispredict;
      upd_valid_q <= pop_en;
      if (order_bad) begin
        err_order_q <= 1'b1;
      end
      if (pop_en) begin
        upd_pc_q    <= bus.ex_pc;
        upd_taken_q <= bus.ex_taken;
        upd_pred_q  <= head_pred;
        if (br_count_q != '1) begin
          br_count_q <= br_count_q + CNT_W'(1);
        end
        if (mispredict) begin
          redirect_pc_q <= bus.ex_taken ? bus.ex_target : (bus.ex_pc + 32'd4);
          if (mispred_count_q != '1) begin
            mispred_count_q <= mispred_count_q + CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.full          = full_w;
  assign bus.flush         = flush_q;
  assign bus.redirect_pc   = redirect_pc_q;
  assign bus.upd_valid     = upd_valid_q;
  assign bus.upd_pc        = upd_pc_q;
  assign bus.upd_taken     = upd_taken_q;
  assign bus.upd_pred      = upd_pred_q;
  assign bus.br_count      = br_count_q;
  assign bus.mispred_count = mispred_count_q;
  assign bus.err_order     = err_order_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  branch_resolve_unit_if #(.CNT_W(32)) bus ();

  branch_resolve_unit #(.DEPTH(4), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_valid  = 1'b0;
    bus.if_is_br  = 1'b0;
    bus.if_pc     = '0;
    bus.if_pred   = '0;
    bus.ex_valid  = 1'b0;
    bus.ex_pc     = '0;
    bus.ex_taken  = 1'b0;
    bus.ex_target = '0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [1:0] pred);
    bus.if_valid = 1'b1;
    bus.if_is_br = 1'b1;
    bus.if_pc    = pc;
    bus.if_pred  = pred;
    tick();
    idle_inputs();
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bus.ex_valid  = 1'b1;
    bus.ex_pc     = pc;
    bus.ex_taken  = taken;
    bus.ex_target = tgt;
    tick();
    idle_inputs();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_full",    32'(bus.full), 32'd0);
    check("rst_flush",   32'(bus.flush), 32'd0);
    check("rst_updv",    32'(bus.upd_valid), 32'd0);
    check("rst_err",     32'(bus.err_order), 32'd0);
    check("rst_br",      bus.br_count, 32'd0);
    check("rst_redir",   bus.redirect_pc, 32'd0);

    // Correct prediction
    push(32'h100, 2'b10);
    tick();
    resolve(32'h100, 1'b1, 32'h180);
    check("ok_updv",     32'(bus.upd_valid), 32'd1);
    check("ok_updpc",    bus.upd_pc, 32'h100);
    check("ok_updpred",  32'(bus.upd_pred), 32'd2);
    check("ok_updtk",    32'(bus.upd_taken), 32'd1);
    check("ok_flush",    32'(bus.flush), 32'd0);
    check("ok_br",       bus.br_count, 32'd1);
    check("ok_mis",      bus.mispred_count, 32'd0);
    tick();
    check("ok_updv_pulse", 32'(bus.upd_valid), 32'd0);

    // Mispredict not-taken -> taken
    push(32'h200, 2'b01);
    resolve(32'h200, 1'b1, 32'h240);
    check("nt2t_flush",  32'(bus.flush), 32'd1);
    check("nt2t_redir",  bus.redirect_pc, 32'h240);
    check("nt2t_mis",    bus.mispred_count, 32'd1);
    check("nt2t_br",     bus.br_count, 32'd2);
    tick();
    check("nt2t_flush_pulse", 32'(bus.flush), 32'd0);
    check("nt2t_redir_hold",  bus.redirect_pc, 32'h240);

    // Mispredict taken -> not-taken with younger entries queued
    push(32'h300, 2'b11);
    push(32'h304, 2'b00);
    push(32'h308, 2'b00);
    resolve(32'h300, 1'b0, 32'h999);
    check("t2nt_flush",  32'(bus.flush), 32'd1);
    check("t2nt_redir",  bus.redirect_pc, 32'h304);
    check("t2nt_mis",    bus.mispred_count, 32'd2);
    // During the flush cycle: push is dropped and EX is ignored
    bus.if_valid = 1'b1; bus.if_is_br = 1'b1; bus.if_pc = 32'h30C; bus.if_pred = 2'b00;
    bus.ex_valid = 1'b1; bus.ex_pc = 32'h304; bus.ex_taken = 1'b1; bus.ex_target = 32'h111;
    tick();
    idle_inputs();
    check("fl_ignore_updv", 32'(bus.upd_valid), 32'd0);
    check("fl_ignore_br",   bus.br_count, 32'd3);
    check("fl_ignore_fl",   32'(bus.flush), 32'd0);

    // Full / wrap: queue must be empty now, so full only after 4 pushes
    push(32'h500, 2'b10);
    push(32'h504, 2'b10);
    push(32'h508, 2'b10);
    check("fill3_full",  32'(bus.full), 32'd0);
    push(32'h50C, 2'b10);
    check("fill4_full",  32'(bus.full), 32'd1);
    // 5th push blocked even with a same-cycle pop
    bus.if_valid = 1'b1; bus.if_is_br = 1'b1; bus.if_pc = 32'h510; bus.if_pred = 2'b00;
    bus.ex_valid = 1'b1; bus.ex_pc = 32'h500; bus.ex_taken = 1'b1; bus.ex_target = 32'h0;
    tick();
    idle_inputs();
    check("blk_full",    32'(bus.full), 32'd0);
    check("blk_updpc",   bus.upd_pc, 32'h500);
    check("blk_flush",   32'(bus.flush), 32'd0);
    resolve(32'h504, 1'b1, 32'h0);
    resolve(32'h508, 1'b1, 32'h0);
    resolve(32'h50C, 1'b1, 32'h0);
    check("drain_updpc", bus.upd_pc, 32'h50C);
    check("drain_br",    bus.br_count, 32'd7);
    for (int i = 0; i < 4; i++) begin
      push(32'h600 + 32'(4 * i), 2'b00);
    end
    check("wrap_full",   32'(bus.full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      resolve(32'h600 + 32'(4 * i), 1'b0, 32'h0);
      check($sformatf("wrap_err%0d", i), 32'(bus.err_order), 32'd0);
    end
    check("wrap_flush",  32'(bus.flush), 32'd0);
    check("wrap_br",     bus.br_count, 32'd11);
    check("wrap_mis",    bus.mispred_count, 32'd2);

    // Ordering error
    push(32'h400, 2'b11);
    resolve(32'h404, 1'b1, 32'h480);
    check("ord_err",     32'(bus.err_order), 32'd1);
    check("ord_updpc",   bus.upd_pc, 32'h404);
    check("ord_updpred", 32'(bus.upd_pred), 32'd3);
    check("ord_flush",   32'(bus.flush), 32'd0);
    tick();
    check("ord_sticky",  32'(bus.err_order), 32'd1);

    // Not-taken redirect wraps past the top of the address space
    push(32'hFFFF_FFFC, 2'b11);
    resolve(32'hFFFF_FFFC, 1'b0, 32'h1234);
    check("wrap4_flush", 32'(bus.flush), 32'd1);
    check("wrap4_redir", bus.redirect_pc, 32'h0);
    tick();

    // Asynchronous reset with three entries queued
    push(32'h700, 2'b10);
    push(32'h704, 2'b10);
    push(32'h708, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_err",    32'(bus.err_order), 32'd0);
    check("arst_br",     bus.br_count, 32'd0);
    check("arst_mis",    bus.mispred_count, 32'd0);
    check("arst_updpc",  bus.upd_pc, 32'd0);
    check("arst_redir",  bus.redirect_pc, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_full",   32'(bus.full), 32'd0);
    // Entries were dropped: a pop now finds an empty queue
    resolve(32'h700, 1'b1, 32'h7A0);
    check("empty_err",   32'(bus.err_order), 32'd1);
    check("empty_pred",  32'(bus.upd_pred), 32'd1);
    check("empty_flush", 32'(bus.flush), 32'd1);
    check("empty_redir", bus.redirect_pc, 32'h7A0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
